axil_reg_ctrl: RTL and testbench

AXI4-Lite slave front-end that sequences the peripheral register block. It accepts AXI-Lite read and write transactions and decodes the word address. It issues single-cycle write and read strobes with one-hot selects to the register block, captures read data and returns OKAY/SLVERR responses. Read and write channels run as independent FSMs sharing one clock.

---
 rtl/axil_reg_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_axil_reg_ctrl.sv | 259 +++++++++++++++++++++++++
 2 files changed

// File: rtl/axil_reg_ctrl.sv
// AXI4-Lite slave front-end for the peripheral register block.
// Two independent FSMs (write, read) turn AXI-Lite transactions into single-cycle
// strobes with one-hot selects towards the register block and return OKAY/SLVERR.
//
// Ports:
//   clk, rst_n           clock, asynchronous active-low reset
//   s_aw*, s_w*, s_b*    AXI-Lite write address / data / response channels
//   s_ar*, s_r*          AXI-Lite read address / data channels
//   wr_en, wdata         write strobe and data to the register block
//   wr_sel_*             one-hot write selects (CTRL 0x0, DATA_IN 0x8)
//   rd_en                read strobe to the register block
//   rd_sel_*             one-hot read selects (CTRL, STATUS, DATA_IN, DATA_OUT)
//   reg_rdata            combinational read data from the register block
module axil_reg_ctrl #(
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DATA_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_W-1:0]     s_awaddr,
  input  logic                  s_awvalid,
  output logic                  s_awready,
  input  logic [DATA_W-1:0]     s_wdata,
  input  logic [DATA_W/8-1:0]   s_wstrb,
  input  logic                  s_wvalid,
  output logic                  s_wready,
  output logic [1:0]            s_bresp,
  output logic                  s_bvalid,
  input  logic                  s_bready,
  input  logic [ADDR_W-1:0]     s_araddr,
  input  logic                  s_arvalid,
  output logic                  s_arready,
  output logic [DATA_W-1:0]     s_rdata,
  output logic [1:0]            s_rresp,
  output logic                  s_rvalid,
  input  logic                  s_rready,
  output logic                  wr_en,
  output logic [DATA_W-1:0]     wdata,
  output logic                  wr_sel_ctrl,
  output logic                  wr_sel_data_in,
  output logic                  rd_en,
  output logic                  rd_sel_ctrl,
  output logic                  rd_sel_status,
  output logic                  rd_sel_data_in,
  output logic                  rd_sel_data_out,
  input  logic [DATA_W-1:0]     reg_rdata
);

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

  typedef enum logic [1:0] {StWIdle, StWExec, StWResp} wr_state_e;
  typedef enum logic [1:0] {StRIdle, StRExec, StRResp} rd_state_e;

  // Keeps every ready low while in reset and opens them on the first edge after release.
  logic live_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live_q <= 1'b0;
    else        live_q <= 1'b1;
  end

  // ---------------------------------------------------------------------------
  // Write channel
  // ---------------------------------------------------------------------------
  wr_state_e             wr_state_q, wr_state_d;
  logic                  aw_held_q, aw_held_d;
  logic                  w_held_q, w_held_d;
  logic [ADDR_W-1:0]     awaddr_q, awaddr_d;
  logic [DATA_W-1:0]     wdata_q, wdata_d;
  logic [DATA_W/8-1:0]   wstrb_q, wstrb_d;
  logic [1:0]            bresp_q, bresp_d;
  logic                  wr_legal;

  // Only CTRL (0x0) and DATA_IN (0x8) are writable, and only as full words.
  assign wr_legal = (awaddr_q[1:0] == 2'b00) && !awaddr_q[2] && (&wstrb_q);

  always_comb begin
    wr_state_d = wr_state_q;
    aw_held_d  = aw_held_q;
    w_held_d   = w_held_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    bresp_d    = bresp_q;
    s_awready  = 1'b0;
    s_wready   = 1'b0;
    s_bvalid   = 1'b0;
    wr_en      = 1'b0;
    unique case (wr_state_q)
      StWIdle: begin
        s_awready = live_q && !aw_held_q;
        s_wready  = live_q && !w_held_q;
        if (s_awready && s_awvalid) begin
          aw_held_d = 1'b1;
          awaddr_d  = s_awaddr;
        end
        if (s_wready && s_wvalid) begin
          w_held_d = 1'b1;
          wdata_d  = s_wdata;
          wstrb_d  = s_wstrb;
        end
        if (aw_held_d && w_held_d) wr_state_d = StWExec;
      end
      StWExec: begin
        wr_en      = wr_legal;
        bresp_d    = wr_legal ? RespOkay : RespSlverr;
        wr_state_d = StWResp;
      end
      StWResp: begin
        s_bvalid = 1'b1;
        if (s_bready) begin
          aw_held_d  = 1'b0;
          w_held_d   = 1'b0;
          wr_state_d = StWIdle;
        end
      end
      default: wr_state_d = StWIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_state_q <= StWIdle;
      aw_held_q  <= 1'b0;
      w_held_q   <= 1'b0;
      awaddr_q   <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      bresp_q    <= RespOkay;
    end else begin
      wr_state_q <= wr_state_d;
      aw_held_q  <= aw_held_d;
      w_held_q   <= w_held_d;
      awaddr_q   <= awaddr_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      bresp_q    <= bresp_d;
    end
  end

  assign s_bresp        = bresp_q;
  assign wdata          = wr_en ? wdata_q : '0;
  assign wr_sel_ctrl    = wr_en && !awaddr_q[3];
  assign wr_sel_data_in = wr_en && awaddr_q[3];

  // ---------------------------------------------------------------------------
  // Read channel
  // ---------------------------------------------------------------------------
  rd_state_e             rd_state_q, rd_state_d;
  logic [ADDR_W-1:0]     araddr_q, araddr_d;
  logic [DATA_W-1:0]     rdata_q, rdata_d;
  logic [1:0]            rresp_q, rresp_d;
  logic                  rd_legal;

  assign rd_legal = (araddr_q[1:0] == 2'b00);

  always_comb begin
    rd_state_d = rd_state_q;
    araddr_d   = araddr_q;
    rdata_d    = rdata_q;
    rresp_d    = rresp_q;
    s_arready  = 1'b0;
    s_rvalid   = 1'b0;
    rd_en      = 1'b0;
    unique case (rd_state_q)
      StRIdle: begin
        s_arready = live_q;
        if (s_arready && s_arvalid) begin
          araddr_d   = s_araddr;
          rd_state_d = StRExec;
        end
      end
      StRExec: begin
        // reg_rdata is sampled at the same edge a concurrent write lands, so it is pre-write.
        rd_en      = rd_legal;
        rdata_d    = rd_legal ? reg_rdata : '0;
        rresp_d    = rd_legal ? RespOkay : RespSlverr;
        rd_state_d = StRResp;
      end
      StRResp: begin
        s_rvalid = 1'b1;
        if (s_rready) rd_state_d = StRIdle;
      end
      default: rd_state_d = StRIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_state_q <= StRIdle;
      araddr_q   <= '0;
      rdata_q    <= '0;
      rresp_q    <= RespOkay;
    end else begin
      rd_state_q <= rd_state_d;
      araddr_q   <= araddr_d;
      rdata_q    <= rdata_d;
      rresp_q    <= rresp_d;
    end
  end

  assign s_rdata         = rdata_q;
  assign s_rresp         = rresp_q;
  assign rd_sel_ctrl     = rd_en && (araddr_q[3:2] == 2'd0);
  assign rd_sel_status   = rd_en && (araddr_q[3:2] == 2'd1);
  assign rd_sel_data_in  = rd_en && (araddr_q[3:2] == 2'd2);
  assign rd_sel_data_out = rd_en && (araddr_q[3:2] == 2'd3);

endmodule

// File: tb/tb_axil_reg_ctrl.sv
module tb_axil_reg_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  s_awaddr;
  logic        s_awvalid;
  logic        s_awready;
  logic [31:0] s_wdata;
  logic [3:0]  s_wstrb;
  logic        s_wvalid;
  logic        s_wready;
  logic [1:0]  s_bresp;
  logic        s_bvalid;
  logic        s_bready;
  logic [3:0]  s_araddr;
  logic        s_arvalid;
  logic        s_arready;
  logic [31:0] s_rdata;
  logic [1:0]  s_rresp;
  logic        s_rvalid;
  logic        s_rready;
  logic        wr_en;
  logic [31:0] wdata;
  logic        wr_sel_ctrl;
  logic        wr_sel_data_in;
  logic        rd_en;
  logic        rd_sel_ctrl;
  logic        rd_sel_status;
  logic        rd_sel_data_in;
  logic        rd_sel_data_out;
  logic [31:0] reg_rdata;

  // Small register-block model; used as the read source when use_model is set.
  logic        use_model = 1'b0;
  logic [31:0] tb_rdata  = 32'h0;
  logic [31:0] ctrl_reg  = 32'h0;
  logic [31:0] din_reg   = 32'h0;
  int          wr_cnt    = 0;
  int          rd_cnt    = 0;
  int          n_checks  = 0;
  int          n_errors  = 0;

  always #5 clk = ~clk;

  axil_reg_ctrl #(.ADDR_W(4), .DATA_W(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .s_awaddr        (s_awaddr),
    .s_awvalid       (s_awvalid),
    .s_awready       (s_awready),
    .s_wdata         (s_wdata),
    .s_wstrb         (s_wstrb),
    .s_wvalid        (s_wvalid),
    .s_wready        (s_wready),
    .s_bresp         (s_bresp),
    .s_bvalid        (s_bvalid),
    .s_bready        (s_bready),
    .s_araddr        (s_araddr),
    .s_arvalid       (s_arvalid),
    .s_arready       (s_arready),
    .s_rdata         (s_rdata),
    .s_rresp         (s_rresp),
    .s_rvalid        (s_rvalid),
    .s_rready        (s_rready),
    .wr_en           (wr_en),
    .wdata           (wdata),
    .wr_sel_ctrl     (wr_sel_ctrl),
    .wr_sel_data_in  (wr_sel_data_in),
    .rd_en           (rd_en),
    .rd_sel_ctrl     (rd_sel_ctrl),
    .rd_sel_status   (rd_sel_status),
    .rd_sel_data_in  (rd_sel_data_in),
    .rd_sel_data_out (rd_sel_data_out),
    .reg_rdata       (reg_rdata)
  );

  assign reg_rdata = !use_model ? tb_rdata :
                     rd_sel_ctrl ? ctrl_reg :
                     rd_sel_data_in ? din_reg : 32'h0;

  always @(posedge clk) begin
    if (wr_en && wr_sel_ctrl)    ctrl_reg <= wdata;
    if (wr_en && wr_sel_data_in) din_reg  <= wdata;
    if (wr_en) wr_cnt <= wr_cnt + 1;
    if (rd_en) rd_cnt <= rd_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  // w_lead > 0: W is presented alone and AW follows w_lead cycles after W is captured.
  task automatic axi_write(input string tag, input logic [3:0] addr, input logic [31:0] data,
                           input logic [3:0] strb, input int w_lead, input logic exp_en,
                           input logic [1:0] exp_sel, input logic [1:0] exp_resp);
    int cnt0;
    cnt0 = wr_cnt;
    @(negedge clk);
    s_wdata  = data;
    s_wstrb  = strb;
    s_wvalid = 1'b1;
    if (w_lead > 0) begin
      @(posedge clk); #1;
      check_eq({tag, "_wready_after_w"}, 32'(s_wready), 32'd0);
      check_eq({tag, "_awready_wait"}, 32'(s_awready), 32'd1);
      @(negedge clk);
      s_wvalid = 1'b0;
      s_wdata  = 32'hDEAD_BEEF;
      repeat (w_lead - 1) @(negedge clk);
    end
    s_awaddr  = addr;
    s_awvalid = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_wr_en"}, 32'(wr_en), 32'(exp_en));
    check_eq({tag, "_wr_sel"}, 32'({wr_sel_ctrl, wr_sel_data_in}), 32'(exp_sel));
    if (exp_en) check_eq({tag, "_wdata"}, wdata, data);
    check_eq({tag, "_rdy_exec"}, 32'({s_awready, s_wready, s_bvalid}), 32'd0);
    @(negedge clk);
    s_awvalid = 1'b0;
    s_wvalid  = 1'b0;
    @(posedge clk); #1;
    check_eq({tag, "_bvalid"}, 32'(s_bvalid), 32'd1);
    check_eq({tag, "_bresp"}, 32'(s_bresp), 32'(exp_resp));
    check_eq({tag, "_wr_en_off"}, 32'(wr_en), 32'd0);
    @(posedge clk); #1;
    check_eq({tag, "_bresp_hold"}, 32'({s_bvalid, s_bresp}), 32'({1'b1, exp_resp}));
    @(negedge clk);
    s_bready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_bvalid_done"}, 32'(s_bvalid), 32'd0);
    check_eq({tag, "_wr_pulses"}, 32'(wr_cnt - cnt0), 32'(exp_en));
    @(negedge clk);
    s_bready = 1'b0;
  endtask

  // exp_sel packs {ctrl, status, data_in, data_out}.
  task automatic axi_read(input string tag, input logic [3:0] addr, input logic [31:0] val,
                          input int hold, input logic exp_en, input logic [3:0] exp_sel,
                          input logic [31:0] exp_data, input logic [1:0] exp_resp);
    int cnt0;
    cnt0 = rd_cnt;
    @(negedge clk);
    s_araddr  = addr;
    s_arvalid = 1'b1;
    tb_rdata  = val;
    @(posedge clk); #1;
    check_eq({tag, "_rd_en"}, 32'(rd_en), 32'(exp_en));
    check_eq({tag, "_rd_sel"},
             32'({rd_sel_ctrl, rd_sel_status, rd_sel_data_in, rd_sel_data_out}), 32'(exp_sel));
    check_eq({tag, "_arready_exec"}, 32'(s_arready), 32'd0);
    @(negedge clk);
    s_arvalid = 1'b0;
    @(posedge clk); #1;
    tb_rdata = 32'h1357_9BDF;
    check_eq({tag, "_rvalid"}, 32'(s_rvalid), 32'd1);
    check_eq({tag, "_rdata"}, s_rdata, exp_data);
    check_eq({tag, "_rresp"}, 32'(s_rresp), 32'(exp_resp));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check_eq({tag, "_rdata_hold"}, s_rdata, exp_data);
      check_eq({tag, "_rvalid_hold"}, 32'({s_rvalid, s_rresp}), 32'({1'b1, exp_resp}));
    end
    @(negedge clk);
    s_rready = 1'b1;
    @(posedge clk); #1;
    check_eq({tag, "_rvalid_done"}, 32'(s_rvalid), 32'd0);
    check_eq({tag, "_rd_pulses"}, 32'(rd_cnt - cnt0), 32'(exp_en));
    @(negedge clk);
    s_rready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] bad_addr [4];
    logic [3:0] bad_strb [4];
    bad_addr = '{4'h4, 4'hC, 4'h2, 4'h8};
    bad_strb = '{4'hF, 4'hF, 4'hF, 4'h3};

    rst_n = 1'b0;
    s_awaddr = '0; s_awvalid = 1'b0; s_wdata = '0; s_wstrb = '0; s_wvalid = 1'b0;
    s_bready = 1'b0; s_araddr = '0; s_arvalid = 1'b0; s_rready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_readies", 32'({s_awready, s_wready, s_arready}), 32'd0);
    check_eq("rst_valids", 32'({s_bvalid, s_rvalid, wr_en, rd_en}), 32'd0);
    check_eq("rst_rdata", s_rdata, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("rel_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);

    axi_write("wr_din", 4'h8, 32'hA5A5_1234, 4'hF, 0, 1'b1, 2'b01, 2'b00);
    axi_write("wr_ctrl_wfirst", 4'h0, 32'h0000_0001, 4'hF, 3, 1'b1, 2'b10, 2'b00);
    check_eq("model_ctrl", ctrl_reg, 32'h0000_0001);
    for (int i = 0; i < 4; i++)
      axi_write($sformatf("wr_bad%0d", i), bad_addr[i], 32'h1111_2222, bad_strb[i], 0,
                1'b0, 2'b00, 2'b10);
    check_eq("model_din_kept", din_reg, 32'hA5A5_1234);

    axi_read("rd_dout", 4'hC, 32'hCAFE_F00D, 4, 1'b1, 4'b0001, 32'hCAFE_F00D, 2'b00);
    axi_read("rd_status", 4'h4, 32'h0000_0055, 0, 1'b1, 4'b0100, 32'h0000_0055, 2'b00);
    axi_read("rd_bad", 4'h1, 32'hFFFF_FFFF, 1, 1'b0, 4'b0000, 32'h0, 2'b10);

    // Concurrent write and read of DATA_IN, with both response readies raised early.
    @(negedge clk);
    use_model = 1'b1;
    s_awaddr = 4'h8; s_wdata = 32'h5555_AAAA; s_wstrb = 4'hF;
    s_awvalid = 1'b1; s_wvalid = 1'b1;
    s_araddr = 4'h8; s_arvalid = 1'b1;
    @(posedge clk); #1;
    check_eq("conc_strobes", 32'({wr_en, rd_en, wr_sel_data_in, rd_sel_data_in}), 32'hF);
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0; s_arvalid = 1'b0;
    s_bready = 1'b1; s_rready = 1'b1;
    @(posedge clk); #1;
    check_eq("conc_valids", 32'({s_bvalid, s_rvalid}), 32'h3);
    check_eq("conc_old_data", s_rdata, 32'hA5A5_1234);
    check_eq("conc_new_reg", din_reg, 32'h5555_AAAA);
    @(posedge clk); #1;
    check_eq("conc_early_ready", 32'({s_bvalid, s_rvalid}), 32'd0);
    @(negedge clk);
    s_bready = 1'b0; s_rready = 1'b0; use_model = 1'b0;

    // Reset with the write in its response phase and the read in its execute cycle.
    @(negedge clk);
    s_awaddr = 4'h0; s_wdata = 32'h2; s_wstrb = 4'hF; s_awvalid = 1'b1; s_wvalid = 1'b1;
    @(negedge clk);
    s_awvalid = 1'b0; s_wvalid = 1'b0;
    s_araddr = 4'h4; s_arvalid = 1'b1;
    @(posedge clk); #1;
    check_eq("prerst_state", 32'({s_bvalid, rd_en}), 32'h3);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("inrst_valids", 32'({s_bvalid, s_rvalid, wr_en, rd_en}), 32'd0);
    check_eq("inrst_readies", 32'({s_awready, s_wready, s_arready}), 32'd0);
    @(negedge clk);
    s_arvalid = 1'b0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("postrst_readies", 32'({s_awready, s_wready, s_arready}), 32'h7);
    check_eq("postrst_valids", 32'({s_bvalid, s_rvalid}), 32'd0);
    @(posedge clk); #1;
    check_eq("postrst_no_resp", 32'({s_bvalid, s_rvalid, rd_en, wr_en}), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
